fifo_sync_fwft_level: RTL and testbench

FIFO_SYNC_FWFT_LEVEL -- requirements
Module: fifo_sync_fwft_level

---
 rtl/fifo_sync_fwft_level.sv | 125 ++++++++++++
 tb/tb_fifo_sync_fwft_level.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_fwft_level.sv
// Synchronous first-word-fall-through FIFO with a registered output stage,
// level/threshold flags and sticky overflow/underflow error reporting.
module fifo_sync_fwft_level #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH / 2,
  parameter int PROG_EMPTY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       prog_full,
  output logic [WIDTH-1:0]           dout,
  input  logic                       rd_en,
  output logic                       empty,
  output logic                       prog_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int MEM_D = DEPTH - 1;  // one word of capacity lives in dout
  localparam int PTR_W = $clog2(MEM_D);

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PFULL  = LVL_W'(PROG_FULL);
  localparam logic [LVL_W-1:0] LVL_PEMPTY = LVL_W'(PROG_EMPTY);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MEM_D - 1);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (PROG_FULL > DEPTH) || (PROG_EMPTY >= DEPTH)) begin : g_bad_params
    $error("fifo_sync_fwft_level: illegal DEPTH/PROG_FULL/PROG_EMPTY combination");
  end

  logic [WIDTH-1:0] mem [MEM_D];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             out_valid;
  logic             wr_acc, rd_acc, mem_has;
  logic             mem_we, pop_mem, load_din, drop_valid;

  assign full       = (level == LVL_FULL);
  assign prog_full  = (level >= LVL_PFULL);
  assign prog_empty = (level <= LVL_PEMPTY);
  assign empty      = !out_valid;
  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && out_valid;
  // Words waiting in the array are everything except the output stage.
  assign mem_has    = (level > LVL_W'(out_valid));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    mem_we     = 1'b0;
    pop_mem    = 1'b0;
    load_din   = 1'b0;
    drop_valid = 1'b0;
    if (rd_acc) begin
      if (mem_has) begin
        pop_mem = 1'b1;
        mem_we  = wr_acc;
      end else if (wr_acc) begin
        load_din = 1'b1;
      end else begin
        drop_valid = 1'b1;
      end
    end else if (wr_acc) begin
      if (out_valid) mem_we = 1'b1;
      else           load_din = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable once
  // the pointers and level are cleared, and leaving it out keeps it plain flops.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= din;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop_mem) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
      end else if (load_din) begin
        dout      <= din;
        out_valid <= 1'b1;
      end else if (drop_valid) begin
        out_valid <= 1'b0;
      end

      if (mem_we) wr_ptr <= ptr_inc(wr_ptr);

      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      // A fresh error in the same cycle outranks the clear request.
      if (wr_en && full)      overflow <= 1'b1;
      else if (err_clr)       overflow <= 1'b0;
      if (rd_en && !out_valid) underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_sync_fwft_level.sv
// Directed bench for fifo_sync_fwft_level at WIDTH=8, DEPTH=4, PROG_FULL=3,
// PROG_EMPTY=1, plus a short random stream checked against a queue model.
module tb_fifo_sync_fwft_level;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en, rd_en, err_clr;
  logic       full, prog_full, empty, prog_empty, overflow, underflow;
  logic [7:0] dout;
  logic [2:0] level;

  int pass_cnt = 0;
  int total    = 0;

  fifo_sync_fwft_level #(
    .WIDTH(8), .DEPTH(4), .PROG_FULL(3), .PROG_EMPTY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full),
    .prog_full(prog_full), .dout(dout), .rd_en(rd_en), .empty(empty),
    .prog_empty(prog_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock with the given inputs; outputs are settled #1 after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 8'h00;
  endtask

  logic [7:0] model_q[$];
  int         sent, drained;
  logic       w, r, m_wacc, m_racc;

  initial begin
    rst_n = 1'b0; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #2;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_prog_full", prog_full, 0);
    check("rst_prog_empty", prog_empty, 1);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_dout", dout, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // First-word fall-through
    step(1, 8'hA5, 0, 0);
    check("fwft_dout", dout, 8'hA5);
    check("fwft_empty", empty, 0);
    check("fwft_level", level, 1);
    check("fwft_prog_empty", prog_empty, 1);
    step(0, 8'h00, 1, 0);
    check("fwft_drain_empty", empty, 1);
    check("fwft_drain_level", level, 0);

    // Fill, overflow, drain in order
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    check("fill2_prog_full", prog_full, 0);
    check("fill2_prog_empty", prog_empty, 0);
    step(1, 8'h03, 0, 0);
    check("fill3_prog_full", prog_full, 1);
    check("fill3_full", full, 0);
    step(1, 8'h04, 0, 0);
    check("fill4_full", full, 1);
    check("fill4_level", level, 4);
    check("fill4_prog_full", prog_full, 1);
    step(1, 8'h05, 0, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_level", level, 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_dout", dout, i);
      step(0, 8'h00, 1, 0);
    end
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);
    check("drain_dout_hold", dout, 8'h04);
    step(0, 8'h00, 0, 1);
    check("ovf_clear", overflow, 0);

    // Simultaneous read/write with one word held
    step(1, 8'h10, 0, 0);
    step(1, 8'h20, 1, 0);
    check("rw1_dout", dout, 8'h20);
    check("rw1_empty", empty, 0);
    check("rw1_level", level, 1);
    step(0, 8'h00, 1, 0);

    // Underflow with a concurrent write; clear priority
    step(1, 8'h33, 1, 0);
    check("unf_flag", underflow, 1);
    check("unf_dout", dout, 8'h33);
    check("unf_level", level, 1);
    step(0, 8'h00, 0, 1);
    check("unf_clear", underflow, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 1);
    check("unf_clr_priority", underflow, 1);
    step(0, 8'h00, 0, 1);
    check("unf_clear2", underflow, 0);

    // Random stream of 20 words against a queue model
    sent = 0; drained = 0;
    for (int cyc = 0; cyc < 400 && drained < 20; cyc++) begin
      w = (sent < 20) && ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      m_wacc = w && (model_q.size() < 4);
      m_racc = r && (model_q.size() > 0);
      step(w, 8'h40 + 8'(sent), r, 0);
      if (m_racc) begin
        void'(model_q.pop_front());
        drained++;
      end
      if (m_wacc) begin
        model_q.push_back(8'h40 + 8'(sent));
        sent++;
      end
      check("stream_level", level, model_q.size());
      check("stream_empty", empty, model_q.size() == 0);
      check("stream_full", full, model_q.size() == 4);
      check("stream_prog_full", prog_full, model_q.size() >= 3);
      check("stream_prog_empty", prog_empty, model_q.size() <= 1);
      if (model_q.size() > 0) check("stream_dout", dout, model_q[0]);
    end
    check("stream_drained", drained, 20);

    // Asynchronous reset mid-operation
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    check("pre_rst_level", level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_dout", dout, 0);
    check("async_rst_prog_empty", prog_empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1, 8'h77, 0, 0);
    check("post_rst_dout", dout, 8'h77);
    check("post_rst_level", level, 1);
    check("post_rst_empty", empty, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
